// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the multiplexed 7-segment scan decoder: segment codes,
// anode codes, scan states and interval-length helpers.
package seg_scan_decoder_pkg;

    localparam int LEN_W = 8;

    // Active-low segment patterns, bit order CA..CG at [6:0]
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_THOU = 4'b0111;
    localparam logic [3:0] AN_HUND = 4'b1011;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_NONE = 4'b1111;
    localparam logic [3:0] AN_ALL  = 4'b0000;

    typedef enum logic [1:0] {
        EXP_THOU = 2'd0,
        EXP_HUND = 2'd1,
        EXP_TENS = 2'd2,
        EXP_ONES = 2'd3
    } scan_state_t;

    function automatic logic [3:0] expected_anode(input scan_state_t s);
        logic [3:0] a;
        case (s)
            EXP_THOU: a = AN_THOU;
            EXP_HUND: a = AN_HUND;
            EXP_TENS: a = AN_TENS;
            default:  a = AN_ONES;
        endcase
        return a;
    endfunction

    function automatic logic [13:0] bcd_to_bin(input logic [3:0] d4, input logic [3:0] d3,
                                               input logic [3:0] d2, input logic [3:0] d1);
        return 14'(d4) * 14'd1000 + 14'(d3) * 14'd100 + 14'(d2) * 14'd10 + 14'(d1);
    endfunction

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
        return (c == {LEN_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD digit decoder with a legality flag.
module seg7_to_bcd
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] led_seg,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (led_seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the displayed value of a 4-digit multiplexed 7-segment meter from
// its anode/segment drive, and measures the visible/blanked interval lengths.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       an,
    input  logic [6:0]       led_seg,
    output logic [3:0]       val4,
    output logic [3:0]       val3,
    output logic [3:0]       val2,
    output logic [3:0]       val1,
    output logic [13:0]      bin_value,
    output logic             frame_valid,
    output logic             seg_err,
    output logic             order_err,
    output logic             blanked,
    output logic [LEN_W-1:0] on_len,
    output logic [LEN_W-1:0] off_len,
    output logic             len_valid
);

    scan_state_t state, state_nxt;

    logic [3:0] digit;
    logic       legal;
    logic       is_blank;
    logic       is_all;
    logic [3:0] sh_thou, sh_hund, sh_tens;
    logic       cap_thou, cap_hund, cap_tens;
    logic       pub_frame, pub_all;
    logic       seg_err_nxt, order_err_nxt;

    logic             seen, armed;
    logic [LEN_W-1:0] on_cnt, off_cnt;

    seg7_to_bcd u_seg7_to_bcd (
        .led_seg (led_seg),
        .digit   (digit),
        .legal   (legal)
    );

    assign is_blank = (an == AN_NONE);
    assign is_all   = (an == AN_ALL);

    always_ff @(posedge clk) begin
        if (rst) state <= EXP_THOU;
        else     state <= state_nxt;
    end

    // Segment legality outranks any anode-order complaint.
    always_comb begin
        state_nxt     = EXP_THOU;
        cap_thou      = 1'b0;
        cap_hund      = 1'b0;
        cap_tens      = 1'b0;
        pub_frame     = 1'b0;
        pub_all       = 1'b0;
        seg_err_nxt   = 1'b0;
        order_err_nxt = 1'b0;
        if (is_blank) begin
            state_nxt = EXP_THOU;
        end else if (!legal) begin
            seg_err_nxt = 1'b1;
        end else if (is_all) begin
            pub_all = 1'b1;
        end else if (an == expected_anode(state)) begin
            case (state)
                EXP_THOU: begin cap_thou = 1'b1; state_nxt = EXP_HUND; end
                EXP_HUND: begin cap_hund = 1'b1; state_nxt = EXP_TENS; end
                EXP_TENS: begin cap_tens = 1'b1; state_nxt = EXP_ONES; end
                EXP_ONES: pub_frame = 1'b1;
            endcase
        end else begin
            order_err_nxt = 1'b1;
            if (an == AN_THOU) begin
                cap_thou  = 1'b1;
                state_nxt = EXP_HUND;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_thou     <= 4'd0;
            sh_hund     <= 4'd0;
            sh_tens     <= 4'd0;
            val4        <= 4'd0;
            val3        <= 4'd0;
            val2        <= 4'd0;
            val1        <= 4'd0;
            bin_value   <= 14'd0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            order_err   <= 1'b0;
        end else begin
            frame_valid <= pub_frame | pub_all;
            seg_err     <= seg_err_nxt;
            order_err   <= order_err_nxt;
            if (cap_thou) sh_thou <= digit;
            if (cap_hund) sh_hund <= digit;
            if (cap_tens) sh_tens <= digit;
            if (pub_frame) begin
                val4      <= sh_thou;
                val3      <= sh_hund;
                val2      <= sh_tens;
                val1      <= digit;
                bin_value <= bcd_to_bin(sh_thou, sh_hund, sh_tens, digit);
            end else if (pub_all) begin
                val4      <= digit;
                val3      <= digit;
                val2      <= digit;
                val1      <= digit;
                bin_value <= bcd_to_bin(digit, digit, digit, digit);
            end
        end
    end

    // The interval in progress at reset has unknown start, so lengths are only
    // reported once a real edge has been seen (armed).
    always_ff @(posedge clk) begin
        if (rst) begin
            blanked   <= 1'b0;
            seen      <= 1'b0;
            armed     <= 1'b0;
            on_cnt    <= '0;
            off_cnt   <= '0;
            on_len    <= '0;
            off_len   <= '0;
            len_valid <= 1'b0;
        end else begin
            blanked   <= is_blank;
            seen      <= 1'b1;
            len_valid <= 1'b0;
            if (seen && (is_blank != blanked)) begin
                armed <= 1'b1;
                if (is_blank) begin
                    if (armed) begin
                        on_len    <= sat_inc(on_cnt);
                        len_valid <= 1'b1;
                    end
                    on_cnt <= '0;
                end else begin
                    if (armed) begin
                        off_len   <= sat_inc(off_cnt);
                        len_valid <= 1'b1;
                    end
                    off_cnt <= '0;
                end
            end else if (seen) begin
                if (is_blank) off_cnt <= sat_inc(off_cnt);
                else          on_cnt  <= sat_inc(on_cnt);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an = 4'b1111;
    logic [6:0]  led_seg = 7'b1111111;
    logic [3:0]  val4, val3, val2, val1;
    logic [13:0] bin_value;
    logic        frame_valid, seg_err, order_err, blanked, len_valid;
    logic [7:0]  on_len, off_len;

    int errors = 0;
    int checks = 0;
    int fv_pulses = 0;
    int lv_pulses = 0;

    logic [6:0] seg_lut [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [3:0] an_seq [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [6:0] BLANK = 7'b1111111;

    seg_scan_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .led_seg     (led_seg),
        .val4        (val4),
        .val3        (val3),
        .val2        (val2),
        .val1        (val1),
        .bin_value   (bin_value),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .order_err   (order_err),
        .blanked     (blanked),
        .on_len      (on_len),
        .off_len     (off_len),
        .len_valid   (len_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One sample: apply inputs, let one posedge register them, look 1 ns later.
    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        an = a;
        led_seg = s;
        @(posedge clk);
        #1;
        if (frame_valid) fv_pulses++;
        if (len_valid) lv_pulses++;
    endtask

    task automatic digit_at(input logic [3:0] a, input int d);
        drive(a, seg_lut[d]);
    endtask

    task automatic scan(input int d4, input int d3, input int d2, input int d1);
        digit_at(4'b0111, d4);
        digit_at(4'b1011, d3);
        digit_at(4'b1101, d2);
        digit_at(4'b1110, d1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(4'b1111, BLANK);
        drive(4'b1111, BLANK);
        rst = 1'b0;
    endtask

    initial begin
        reset_dut();
        chk("rst_vals", 32'({val4, val3, val2, val1}), 32'h0);
        chk("rst_bin", 32'(bin_value), 0);
        chk("rst_pulses", 32'({frame_valid, seg_err, order_err, len_valid}), 0);
        chk("rst_lens", 32'({blanked, on_len, off_len}), 0);

        // All-anode reset display
        digit_at(4'b0000, 0);
        chk("all0_fv", 32'(frame_valid), 1);
        chk("all0_vals", 32'({val4, val3, val2, val1}), 32'h0);
        chk("all0_err", 32'({seg_err, order_err}), 0);
        digit_at(4'b0000, 7);
        chk("all7_vals", 32'({val4, val3, val2, val1}), 32'h7777);
        chk("all7_bin", 32'(bin_value), 7777);

        // Clean scan 1234
        digit_at(4'b0111, 1);
        chk("thou_nofv", 32'(frame_valid), 0);
        digit_at(4'b1011, 2);
        digit_at(4'b1101, 3);
        digit_at(4'b1110, 4);
        chk("s1234_fv", 32'(frame_valid), 1);
        chk("s1234_vals", 32'({val4, val3, val2, val1}), 32'h1234);
        chk("s1234_bin", 32'(bin_value), 1234);
        fv_pulses = 0;
        scan(1, 2, 3, 4);
        scan(1, 2, 3, 4);
        chk("repeat_pulses", 32'(fv_pulses), 2);

        // Illegal pattern in hundreds slot
        digit_at(4'b0111, 1);
        drive(4'b1011, 7'b1111110);
        chk("segerr_pulse", 32'(seg_err), 1);
        chk("segerr_noorder", 32'(order_err), 0);
        chk("segerr_nofv", 32'(frame_valid), 0);
        chk("segerr_bin", 32'(bin_value), 1234);
        scan(9, 9, 9, 9);
        chk("s9999_bin", 32'(bin_value), 9999);
        chk("s9999_vals", 32'({val4, val3, val2, val1}), 32'h9999);
        chk("s9999_segerr", 32'(seg_err), 0);

        // Illegal pattern on the wrong anode: seg_err only
        digit_at(4'b0111, 1);
        drive(4'b1110, 7'b0110110);
        chk("prio_seg", 32'(seg_err), 1);
        chk("prio_order", 32'(order_err), 0);

        // Out-of-sequence digits
        digit_at(4'b0111, 5);
        chk("ord_ok", 32'(order_err), 0);
        digit_at(4'b1101, 0);
        chk("ord_skip", 32'(order_err), 1);
        chk("ord_nofv", 32'(frame_valid), 0);
        digit_at(4'b1011, 2);
        chk("ord_hund_ign", 32'(order_err), 1);
        scan(5, 6, 7, 8);
        chk("s5678_bin", 32'(bin_value), 5678);
        chk("s5678_order", 32'(order_err), 0);

        // Two active anodes
        digit_at(4'b0011, 3);
        chk("multi_order", 32'(order_err), 1);
        chk("multi_nofv", 32'(frame_valid), 0);

        // Repeated thousands restarts the frame on the new digit
        digit_at(4'b0111, 2);
        digit_at(4'b0111, 3);
        chk("rethou_order", 32'(order_err), 1);
        digit_at(4'b1011, 4);
        digit_at(4'b1101, 5);
        digit_at(4'b1110, 6);
        chk("rethou_fv", 32'(frame_valid), 1);
        chk("rethou_bin", 32'(bin_value), 3456);

        // Blank mid-frame discards quietly
        digit_at(4'b0111, 1);
        drive(4'b1111, BLANK);
        chk("blank_noerr", 32'({seg_err, order_err}), 0);
        digit_at(4'b1011, 2);
        chk("blank_restart", 32'(order_err), 1);
        chk("blank_bin", 32'(bin_value), 3456);

        // Interval lengths
        reset_dut();
        lv_pulses = 0;
        repeat (3) drive(4'b1111, BLANK);
        for (int i = 0; i < 50; i++) digit_at(an_seq[i % 4], 1);
        chk("len_arm_quiet", 32'(lv_pulses), 0);
        drive(4'b1111, BLANK);
        chk("on_len50", 32'(on_len), 50);
        chk("on_lv", 32'(len_valid), 1);
        chk("blanked_hi", 32'(blanked), 1);
        repeat (49) drive(4'b1111, BLANK);
        digit_at(4'b0111, 1);
        chk("off_len50", 32'(off_len), 50);
        chk("off_lv", 32'(len_valid), 1);
        chk("lv_pulses2", 32'(lv_pulses), 2);
        drive(4'b1111, BLANK);
        chk("on_len1", 32'(on_len), 1);
        repeat (299) drive(4'b1111, BLANK);
        digit_at(4'b0111, 1);
        chk("off_len_sat", 32'(off_len), 255);

        // Reset mid-frame
        reset_dut();
        digit_at(4'b0111, 1);
        digit_at(4'b1011, 2);
        digit_at(4'b1101, 3);
        rst = 1'b1;
        digit_at(4'b1110, 4);
        chk("midrst_fv", 32'(frame_valid), 0);
        chk("midrst_vals", 32'({val4, val3, val2, val1}), 32'h0);
        chk("midrst_bin", 32'(bin_value), 0);
        rst = 1'b0;
        fv_pulses = 0;
        scan(4, 3, 2, 1);
        chk("postrst_bin", 32'(bin_value), 4321);
        chk("postrst_pulses", 32'(fv_pulses), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have these ports (clock and reset first): clk  in  1  system clock (100 Hz meter clock).
REQ-002 SHALL have: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have: an  in  4  anode bus {a4,a3,a2,a1}; active-low; a4=thousands, a1=ones.
REQ-004 SHALL have: led_seg  in  7  segments [CA..CG] at bits [6:0]; active-low.
REQ-005 SHALL have: val4..val1  out  4 each  last complete frame as BCD digits (thousands..ones).
REQ-006 SHALL have: bin_value  out  14  binary value of the last frame (val4*1000+val3*100+val2*10+val1).
REQ-007 SHALL have: frame_valid  out  1  one-cycle pulse when a new frame is published.
REQ-008 SHALL have: seg_err  out  1  one-cycle pulse for an illegal segment pattern on a single active anode.
REQ-009 SHALL have: order_err  out  1  one-cycle pulse for an out-of-sequence digit or an illegal anode combination.
REQ-010 SHALL have: blanked  out  1  registered copy of (an==4'b1111).
REQ-011 SHALL have: on_len, off_len  out  8 each  length in clk cycles of the last visible and last blanked interval, saturating at 255.
REQ-012 SHALL have: len_valid  out  1  one-cycle pulse when on_len or off_len updates.

Function
REQ-013 SHALL decode patterns 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0000100 to digits 0-9; every other pattern is illegal.
REQ-014 SHALL sample an/led_seg at every posedge; all outputs registered; no input synchronizers (source is same-clock registered).
REQ-015 SHALL run an FSM with states EXP_THOU, EXP_HUND, EXP_TENS, EXP_ONES; reset state EXP_THOU.
REQ-016 SHALL accept expected one-hot code (0111, 1011, 1101, 1110 respectively) with a legal pattern: store the digit in a shadow register and advance; from EXP_ONES, return to EXP_THOU.
REQ-017 SHALL, on accepting the ones digit at edge N, load val4..val1 and bin_value atomically at edge N and drive frame_valid high during cycle N..N+1 only.
REQ-018 SHALL, on an==1111, go to EXP_THOU, discard the partial frame, and flag no error.
REQ-019 SHALL, on a single active anode that is not the expected one: pulse order_err, discard the partial frame; if that anode is thousands with a legal pattern, capture it and go to EXP_HUND, else go to EXP_THOU.
REQ-020 SHALL, on an==0000 with a legal pattern: load all four digits with that digit, publish the frame (frame_valid pulse), go to EXP_THOU, and flag no error. This is the all-digit reset display.
REQ-021 SHALL, on any other multi-anode code (2 or 3 active): pulse order_err and go to EXP_THOU.
REQ-022 SHALL, on an illegal pattern: pulse seg_err, go to EXP_THOU, and publish nothing. An illegal pattern takes priority over order_err, so only seg_err pulses.
REQ-023 SHALL compute bin_value from the shadow digits and the incoming ones digit, with no extra latency; the result fits in 14 bits, max 9999.
REQ-024 SHALL keep on_cnt/off_cnt (8 bits, saturating) counting consecutive visible/blanked cycles.
REQ-025 SHALL, on a visible->blanked transition: on_len<=on_cnt+1 (saturated), clear on_cnt, pulse len_valid; symmetric rule for blanked->visible into off_len.
REQ-026 SHALL not count the first interval after reset as a transition source until the first edge change is observed.

Reset
REQ-027 SHALL on rst: FSM=EXP_THOU, shadows/val4..val1=0, bin_value=0, frame_valid/seg_err/order_err/len_valid=0, blanked=0, on_len/off_len/counters=0.
REQ-028 SHALL give rst priority over all inputs; rst mid-frame discards the partial frame and produces no pulses.

Structure
REQ-029 SHALL place in a shared package: the ten segment pattern constants, the blank pattern 1111111, the four anode one-hot codes, the FSM state encoding, and the length width (8).
REQ-030 SHALL use one sub-module, seg7_to_bcd (combinational: led_seg -> digit[3:0], legal flag); all remaining logic is in seg_scan_decoder.

Verification
REQ-031 SHALL cover: after rst, drive an=0000/seg=0000001 for one cycle -> frame_valid pulse, val=0,0,0,0, bin_value=0.
REQ-032 SHALL cover: consecutive 0111/"1", 1011/"2", 1101/"3", 1110/"4" -> frame_valid one cycle after the ones sample, val=1,2,3,4, bin_value=1234; repeated scan yields one pulse per 4 cycles.
REQ-033 SHALL cover: 1111110 in the hundreds slot -> seg_err pulse, no frame_valid, outputs unchanged; next clean scan of 9999 -> bin_value=9999.
REQ-034 SHALL cover: 0111/"5" then 1101/"0" -> order_err, no frame; then 1011 ignored with order_err; full scan recovers.
REQ-035 SHALL cover: 50 cycles of scanning, 50 cycles an=1111, then scanning -> on_len=50, off_len=50, two len_valid pulses; 300 blanked cycles -> off_len=255.
REQ-036 SHALL cover: rst asserted after the tens digit is accepted -> no frame_valid; val/bin_value=0; the next full scan publishes normally.
